// File: rtl/neopixel_stream_engine_if.sv
// Pixel-buffer read port between the stream engine (master) and the buffer owner (slave).
// mem_data is expected to be a combinational read of mem_addr.
interface neopixel_stream_engine_if #(
    parameter int BUFFER_BITS = 6
);
    logic [BUFFER_BITS-1:0] mem_addr;
    logic [7:0]             mem_data;

    modport master (output mem_addr, input  mem_data);
    modport slave  (input  mem_addr, output mem_data);
endinterface

// File: rtl/neopixel_stream_engine.sv
// WS2812 serialiser: walks the pixel buffer byte by byte, emits 8-tick bit cells
// on neo_data, then holds a latch period before the next frame.
module neopixel_stream_engine #(
    parameter int BUFFER_END  = 59,
    parameter int RESET_DELAY = 385
) (
    input  logic                     clk7mhz,
    input  logic                     rst,
    input  logic                     ctrl_init,
    input  logic                     ctrl_run,
    input  logic                     ctrl_loop,
    input  logic                     ctrl_limit,
    input  logic                     ctrl_32bit,
    input  logic [12:0]              reg_max,
    neopixel_stream_engine_if.master mem,
    output logic                     neo_data,
    output logic                     neo_state,
    output logic                     pixels_sync,
    output logic                     run_done
);
    localparam int BUFFER_BITS = $clog2(BUFFER_END + 1);
    localparam int MAX24       = (BUFFER_END + 1) / 3 - 1;
    localparam int MAX32       = (BUFFER_END + 1) / 4 - 1;

    typedef enum logic {
        ST_TRANSMIT = 1'b0,
        ST_RESET    = 1'b1
    } state_t;

    state_t                 r_state, w_state_nx;
    logic [2:0]             r_pat, w_pat_nx;
    logic [4:0]             r_bit, w_bit_nx;
    logic [BUFFER_BITS-1:0] r_pix, w_pix_nx;
    logic [9:0]             r_cnt, w_cnt_nx;
    logic                   r_neo, w_neo_nx;

    logic [12:0]            w_def_max;
    logic [12:0]            w_pix_max;
    logic                   w_last_pix;
    logic [BUFFER_BITS-1:0] w_addr24;
    logic [BUFFER_BITS-1:0] w_addr32;
    logic                   w_d;

    // Compared in 13 bits so a reg_max above the buffer capacity clamps cleanly.
    assign w_def_max  = ctrl_32bit ? 13'(MAX32) : 13'(MAX24);
    assign w_pix_max  = (ctrl_limit && (reg_max < w_def_max)) ? reg_max : w_def_max;
    assign w_last_pix = (13'(r_pix) >= w_pix_max);

    assign w_addr24 = BUFFER_BITS'({2'b00, r_pix} + {1'b0, r_pix, 1'b0}
                                   + {{BUFFER_BITS{1'b0}}, r_bit[4:3]});
    assign w_addr32 = BUFFER_BITS'({r_pix, r_bit[4:3]});
    assign mem.mem_addr = ctrl_32bit ? w_addr32 : w_addr24;

    assign w_d = mem.mem_data[3'd7 - r_bit[2:0]];

    always_comb begin
        w_state_nx = r_state;
        w_pat_nx   = r_pat;
        w_bit_nx   = r_bit;
        w_pix_nx   = r_pix;
        w_cnt_nx   = r_cnt;
        w_neo_nx   = 1'b0;
        case (r_state)
            ST_TRANSMIT: begin
                if (ctrl_run) begin
                    w_neo_nx = (r_pat < (w_d ? 3'd6 : 3'd3));
                    w_pat_nx = r_pat + 3'd1;
                    if (r_pat == 3'd7) begin
                        if (r_bit == 5'd23) begin
                            w_bit_nx = 5'd0;
                            if (w_last_pix) begin
                                w_pix_nx   = '0;
                                w_state_nx = ST_RESET;
                            end else begin
                                w_pix_nx = r_pix + BUFFER_BITS'(1);
                            end
                        end else begin
                            w_bit_nx = r_bit + 5'd1;
                        end
                    end
                end
            end
            ST_RESET: begin
                if (r_cnt == 10'(RESET_DELAY + 1)) begin
                    w_cnt_nx   = 10'd0;
                    w_state_nx = ST_TRANSMIT;
                end else begin
                    w_cnt_nx = r_cnt + 10'd1;
                end
            end
            default: w_state_nx = ST_TRANSMIT;
        endcase
    end

    always_ff @(posedge clk7mhz) begin
        if (rst || ctrl_init) begin
            r_state <= ST_TRANSMIT;
            r_pat   <= 3'd0;
            r_bit   <= 5'd0;
            r_pix   <= '0;
            r_cnt   <= 10'd0;
            r_neo   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pat   <= w_pat_nx;
            r_bit   <= w_bit_nx;
            r_pix   <= w_pix_nx;
            r_cnt   <= w_cnt_nx;
            r_neo   <= w_neo_nx;
        end
    end

    assign neo_data    = r_neo;
    assign neo_state   = r_state;
    assign pixels_sync = (r_state == ST_RESET);
    assign run_done    = (r_state == ST_RESET) && (r_cnt == 10'(RESET_DELAY)) && !ctrl_loop;
endmodule

// File: tb/tb_neopixel_stream_engine.sv
// Directed bench for neopixel_stream_engine with a 12-byte buffer and a 10-tick latch.
module tb_neopixel_stream_engine;
    localparam int BE = 11;
    localparam int RD = 10;
    localparam int BB = 4;

    logic        clk;
    logic        rst, ctrl_init, ctrl_run, ctrl_loop, ctrl_limit, ctrl_32bit;
    logic [12:0] reg_max;
    logic        neo_data, neo_state, pixels_sync, run_done;
    logic [7:0]  mem_q [0:15];

    int n_tests = 0;
    int n_fail  = 0;

    neopixel_stream_engine_if #(.BUFFER_BITS(BB)) mem_if ();
    assign mem_if.mem_data = mem_q[mem_if.mem_addr];

    neopixel_stream_engine #(.BUFFER_END(BE), .RESET_DELAY(RD)) dut (
        .clk7mhz    (clk),
        .rst        (rst),
        .ctrl_init  (ctrl_init),
        .ctrl_run   (ctrl_run),
        .ctrl_loop  (ctrl_loop),
        .ctrl_limit (ctrl_limit),
        .ctrl_32bit (ctrl_32bit),
        .reg_max    (reg_max),
        .mem        (mem_if),
        .neo_data   (neo_data),
        .neo_state  (neo_state),
        .pixels_sync(pixels_sync),
        .run_done   (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial level produced from counter position t in 24-bit mode.
    function automatic logic exp_neo(input int t);
        int b, p;
        logic [7:0] byt;
        b   = (t / 8) % 24;
        p   = t / 192;
        byt = mem_q[p * 3 + b / 8];
        return (t % 8) < (byt[7 - b % 8] ? 6 : 3);
    endfunction

    function automatic int exp_addr24(input int t);
        return (t / 192) * 3 + ((t / 8) % 24) / 8;
    endfunction

    task automatic do_reset();
        rst = 1'b1; ctrl_init = 1'b0; ctrl_run = 1'b0; ctrl_loop = 1'b1;
        ctrl_limit = 1'b0; ctrl_32bit = 1'b0; reg_max = 13'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem_q[i] = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({neo_data, neo_state, pixels_sync, run_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {neo_data, neo_state, pixels_sync, run_done});
        end
        n_tests++;
        if (mem_if.mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d expected 0", mem_if.mem_addr);
        end
    endtask

    task automatic test_first_pixel();
        clear_mem();
        mem_q[0] = 8'h80;
        do_reset();
        ctrl_run = 1'b1;
        for (int k = 1; k <= 192; k++) begin
            tick();
            n_tests++;
            if (neo_data !== exp_neo(k - 1)) begin
                n_fail++;
                $display("FAIL first_pixel_neo t=%0d: got %b expected %b", k, neo_data, exp_neo(k - 1));
            end
            n_tests++;
            if (int'(mem_if.mem_addr) !== exp_addr24(k)) begin
                n_fail++;
                $display("FAIL first_pixel_addr t=%0d: got %0d expected %0d", k, mem_if.mem_addr, exp_addr24(k));
            end
        end
    endtask

    // Runs one frame from reset and checks its length, the latch window and run_done.
    task automatic test_frame(input string name, input logic lim, input logic [12:0] rmax,
                              input logic b32, input logic lp, input int exp_len);
        int k, n, pulses, pos, bad;
        do_reset();
        ctrl_limit = lim; reg_max = rmax; ctrl_32bit = b32; ctrl_loop = lp;
        ctrl_run = 1'b1;
        k = 0;
        while (!neo_state && k < 3000) begin tick(); k++; end
        n_tests++;
        if (k !== exp_len) begin
            n_fail++;
            $display("FAIL %s frame_len: got %0d expected %0d", name, k, exp_len);
        end
        n = 0; pulses = 0; pos = 0; bad = 0;
        while (neo_state && n < 100) begin
            n++;
            if (run_done) begin pulses++; pos = n; end
            if (pixels_sync !== 1'b1 || neo_data !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (n !== RD + 2) begin
            n_fail++;
            $display("FAIL %s latch_len: got %0d expected %0d", name, n, RD + 2);
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL %s latch_outputs: got %0d bad ticks expected 0", name, bad);
        end
        n_tests++;
        if (pulses !== (lp ? 0 : 1)) begin
            n_fail++;
            $display("FAIL %s run_done_count: got %0d expected %0d", name, pulses, lp ? 0 : 1);
        end
        if (!lp) begin
            n_tests++;
            if (pos !== RD + 1) begin
                n_fail++;
                $display("FAIL %s run_done_pos: got %0d expected %0d", name, pos, RD + 1);
            end
        end
        n_tests++;
        if (pixels_sync !== 1'b0 || mem_if.mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL %s after_latch: got sync=%b addr=%0d expected sync=0 addr=0",
                     name, pixels_sync, mem_if.mem_addr);
        end
        if (lp) begin
            k = 0;
            while (!neo_state && k < 3000) begin tick(); k++; end
            n_tests++;
            if (k !== exp_len) begin
                n_fail++;
                $display("FAIL %s second_frame_len: got %0d expected %0d", name, k, exp_len);
            end
        end
    endtask

    task automatic test_addr_32();
        int seq [$];
        int exp_seq [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int last;
        do_reset();
        ctrl_32bit = 1'b1;
        ctrl_run   = 1'b1;
        last = int'(mem_if.mem_addr);
        seq.push_back(last);
        for (int k = 1; k < 576; k++) begin
            tick();
            if (int'(mem_if.mem_addr) != last) begin
                last = int'(mem_if.mem_addr);
                seq.push_back(last);
            end
        end
        n_tests++;
        if (seq.size() !== 9) begin
            n_fail++;
            $display("FAIL addr32_count: got %0d expected 9", seq.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                n_tests++;
                if (seq[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL addr32_seq[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_init_in_latch();
        int k;
        do_reset();
        ctrl_limit = 1'b1; reg_max = 13'd0; ctrl_run = 1'b1;
        k = 0;
        while (!neo_state && k < 1000) begin tick(); k++; end
        n_tests++;
        if (k !== 192) begin
            n_fail++;
            $display("FAIL init_frame_len: got %0d expected 192", k);
        end
        tick(); tick();
        ctrl_init = 1'b1;
        tick();
        ctrl_init = 1'b0;
        n_tests++;
        if ({neo_state, pixels_sync, neo_data} !== 3'b000 || mem_if.mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL init_in_latch: got state=%b sync=%b neo=%b addr=%0d expected all 0",
                     neo_state, pixels_sync, neo_data, mem_if.mem_addr);
        end
    endtask

    task automatic test_pause_and_reset();
        int bad;
        clear_mem();
        mem_q[0] = 8'h80;
        mem_q[1] = 8'h08;
        do_reset();
        ctrl_run = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        ctrl_run = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (neo_data !== 1'b0 || mem_if.mem_addr !== 4'd1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL pause_hold: got %0d bad ticks expected 0", bad);
        end
        ctrl_run = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            tick();
            n_tests++;
            if (neo_data !== exp_neo(100 + j - 1)) begin
                n_fail++;
                $display("FAIL resume_neo j=%0d: got %b expected %b", j, neo_data, exp_neo(100 + j - 1));
            end
        end
        for (int k = 0; k < 164; k++) tick();
        n_tests++;
        if (mem_if.mem_addr !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_rst_addr: got %0d expected 4", mem_if.mem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({neo_data, neo_state, pixels_sync, run_done} !== 4'b0000 || mem_if.mem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL midframe_rst: got outs=%b addr=%0d expected 0000 addr=0",
                     {neo_data, neo_state, pixels_sync, run_done}, mem_if.mem_addr);
        end
        tick();
        n_tests++;
        if (neo_data !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_restart: got %b expected 1", neo_data);
        end
    endtask

    initial begin
        clear_mem();
        rst = 1'b1; ctrl_init = 1'b0; ctrl_run = 1'b0; ctrl_loop = 1'b1;
        ctrl_limit = 1'b0; ctrl_32bit = 1'b0; reg_max = 13'd0;
        tick();
        test_reset();
        test_first_pixel();
        test_frame("loop24", 1'b0, 13'd0, 1'b0, 1'b1, 768);
        test_frame("oneshot24", 1'b0, 13'd0, 1'b0, 1'b0, 768);
        test_frame("mode32", 1'b0, 13'd0, 1'b1, 1'b1, 576);
        test_frame("limit1", 1'b1, 13'd1, 1'b0, 1'b1, 384);
        test_frame("limit100", 1'b1, 13'd100, 1'b0, 1'b1, 768);
        test_addr_32();
        test_init_in_latch();
        test_pause_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
